// File: rtl/ddr3_fifo_traffic_checker.sv
// Traffic source/sink for the DDR3_top user FIFOs. It writes TOTAL incrementing
// words, waits for write-back, then reads them back and counts mismatches.
// The run ends with done and pass/timeout. An idle watchdog aborts runs that stall.
module ddr3_fifo_traffic_checker #(
    parameter int                DATA_W     = 64,
    parameter int                BURST_LEN  = 16,
    parameter int                NUM_BURSTS = 4,
    parameter logic [DATA_W-1:0] SEED       = '0,
    parameter int                RD_LAT     = 1,
    parameter int                TIMEOUT    = 4096
) (
    input  logic              clk_200M,
    input  logic              rst_n,
    input  logic              rst_busy,
    input  logic              start,
    output logic              wr_en,
    output logic [DATA_W-1:0] wrdat,
    input  logic              full,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rddat,
    input  logic              empty,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt
);
    localparam int TOTAL = BURST_LEN * NUM_BURSTS;
    localparam int CNT_W = 17;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_WRITE, S_RD_WAIT, S_READ, S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   wrdat_reg, exp_reg;
    logic [CNT_W-1:0]    wr_cnt_reg, rd_issued_reg, cmp_cnt_reg;
    logic [3:0]          rdw_cnt_reg;
    logic [TO_W-1:0]     idle_cnt_reg;
    logic                rd_pend_reg, timeout_reg;
    logic [15:0]         err_cnt_reg;

    logic start_ok, counting, idle_hit, timeout_fire;
    logic cmp_valid, cmp_last, wr_last;

    // Control decodes shared by the FSM and the datapath.
    always_comb begin
        start_ok  = start && (state_reg == S_IDLE || state_reg == S_DONE);
        counting  = (state_reg == S_WAIT_RDY) || (state_reg == S_WRITE) || (state_reg == S_READ);
        // A registered rd_en means rddat of the previous pop is on the bus now.
        cmp_valid = (state_reg == S_READ) && ((RD_LAT == 0) ? rd_en : rd_pend_reg);
        cmp_last  = cmp_valid && (cmp_cnt_reg == CNT_W'(TOTAL - 1));
        wr_last   = wr_en && (wr_cnt_reg == CNT_W'(TOTAL - 1));
        idle_hit  = counting && !(wr_en || rd_en) && (idle_cnt_reg == TO_W'(TIMEOUT - 1));
        // Leaving WAIT_RDY and finishing the last compare win over the watchdog.
        timeout_fire = idle_hit && !cmp_last && !(state_reg == S_WAIT_RDY && !rst_busy);
    end

    // State register.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (start) state_next = S_WAIT_RDY;
            S_WAIT_RDY: if (!rst_busy) state_next = S_WRITE;
                        else if (timeout_fire) state_next = S_DONE;
            S_WRITE:    if (wr_last) state_next = S_RD_WAIT;
                        else if (timeout_fire) state_next = S_DONE;
            S_RD_WAIT:  if (rdw_cnt_reg == 4'd15) state_next = S_READ;
            S_READ:     if (cmp_last || timeout_fire) state_next = S_DONE;
            S_DONE:     if (start) state_next = S_WAIT_RDY;
            default:    state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state; full/empty gate the same cycle.
    always_comb begin
        wr_en = (state_reg == S_WRITE) && !full && !rst_busy;
        rd_en = (state_reg == S_READ) && !empty && !rst_busy && (rd_issued_reg < CNT_W'(TOTAL));
        busy  = counting || (state_reg == S_RD_WAIT);
        done  = (state_reg == S_DONE);
        pass  = (state_reg == S_DONE) && (err_cnt_reg == 16'd0) && !timeout_reg;
    end

    // Datapath: write/read counters, expected-word generator, error count, watchdog.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            wrdat_reg     <= SEED;
            exp_reg       <= SEED;
            wr_cnt_reg    <= '0;
            rd_issued_reg <= '0;
            cmp_cnt_reg   <= '0;
            rdw_cnt_reg   <= '0;
            idle_cnt_reg  <= '0;
            rd_pend_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            rd_pend_reg <= rd_en;

            if (state_next != state_reg || wr_en || rd_en) idle_cnt_reg <= '0;
            else if (counting)                            idle_cnt_reg <= idle_cnt_reg + TO_W'(1);

            if (state_reg == S_RD_WAIT) rdw_cnt_reg <= rdw_cnt_reg + 4'd1;
            else                        rdw_cnt_reg <= 4'd0;

            if (start_ok) begin
                wrdat_reg     <= SEED;
                exp_reg       <= SEED;
                wr_cnt_reg    <= '0;
                rd_issued_reg <= '0;
                cmp_cnt_reg   <= '0;
                timeout_reg   <= 1'b0;
                err_cnt_reg   <= '0;
            end else begin
                if (wr_en) begin
                    wrdat_reg  <= wrdat_reg + DATA_W'(1);
                    wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
                end
                if (rd_en) rd_issued_reg <= rd_issued_reg + CNT_W'(1);
                if (cmp_valid) begin
                    cmp_cnt_reg <= cmp_cnt_reg + CNT_W'(1);
                    exp_reg     <= exp_reg + DATA_W'(1);
                    if (rddat != exp_reg && err_cnt_reg != 16'hFFFF)
                        err_cnt_reg <= err_cnt_reg + 16'd1;
                end
                if (timeout_fire) timeout_reg <= 1'b1;
            end
        end
    end

    assign wrdat   = wrdat_reg;
    assign timeout = timeout_reg;
    assign err_cnt = err_cnt_reg;

endmodule
